// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//
// Contents:
//   REG_W / DATA_W   register-index and datapath widths
//   SZ_*             access-size encodings carried down from EXE/MEM
//   mem_state_e      MEM-stage FSM states
//   is_misaligned()  alignment rule shared by the stage and its lane logic
package mem_stage_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 32;

  // The reserved size code 2'b11 is handled as a word everywhere.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_WAIT_WB = 2'd2
  } mem_state_e;

  // A halfword must sit on an even address and a word on a multiple of
  // four. Bytes can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory port (purely combinational).
//
// Ports:
//   addr_lo        in   2   low address bits selecting the byte within a word
//   size           in   2   access size (SZ_BYTE / SZ_HALF / word)
//   signed_ext     in   1   sign-extend byte/halfword load data
//   little_endian  in   1   1: byte 0 at [7:0], 0: byte 0 at [31:24]
//   store_data     in  32   raw store operand
//   load_raw       in  32   raw word returned by memory
//   be             out  4   byte enables for the addressed lanes
//   wdata          out 32   store data replicated across all lanes
//   load_data      out 32   addressed lane, zero- or sign-extended
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              signed_ext,
  input  logic              little_endian,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] load_raw,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);

  logic [1:0]  byte_lane;
  logic        half_hi;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Big-endian mode mirrors the lane index (3 - lane, i.e. the bitwise
  // complement of the two address bits). For halfwords this flips which
  // half of the bus holds the addressed pair. Replicating store data over
  // every lane lets the byte enables alone pick the destination.
  always_comb begin
    byte_lane = little_endian ? addr_lo : ~addr_lo;
    half_hi   = little_endian ? addr_lo[1] : ~addr_lo[1];
    byte_val  = load_raw[{byte_lane, 3'b000} +: 8];
    half_val  = half_hi ? load_raw[31:16] : load_raw[15:0];

    be        = 4'b1111;
    wdata     = store_data;
    load_data = load_raw;

    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << byte_lane;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{signed_ext & byte_val[7]}}, byte_val};
      end
      SZ_HALF: begin
        be        = half_hi ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{signed_ext & half_val[15]}}, half_val};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = load_raw;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline. Runs one req/ack data-memory
// transaction per load/store, stalls upstream until it completes, and
// registers the result into the MEM/WB outputs.
//
// Parameters:
//   TIMEOUT        cycles to wait for mem_ack before aborting (>= 2)
//   LITTLE_ENDIAN  byte-lane order of the memory bus
//
// Ports:
//   clk, reset_n                  clock (rising edge), async active-low reset
//   addr_in, store_data_in        effective address / store operand (EXE/MEM)
//   rd_in, size_in                destination register, access size
//   load_in, store_in, signed_in  operation flags (store wins if both set)
//   rf_en_in                      register-file write enable
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be             data-memory request (held during ACCESS)
//   mem_rdata, mem_ack            data-memory response
//   stall                         freeze IF/ID/EXE and EXE/MEM
//   wb_data, wb_rd, wb_rf_en      MEM/WB register
//   mem_fault                     one-cycle pulse on misalignment or timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT       = 16,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [1:0]        size_in,
  input  logic              load_in,
  input  logic              store_in,
  input  logic              signed_in,
  input  logic              rf_en_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_rf_en,
  output logic              mem_fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] ACCESS  = ST_ACCESS;
  localparam logic [1:0] WAIT_WB = ST_WAIT_WB;

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic              op_done;

  // Request fields captured when the FSM leaves IDLE.
  logic [DATA_W-1:0] lat_addr;
  logic [REG_W-1:0]  lat_rd;
  logic [1:0]        lat_size;
  logic              lat_load;
  logic              lat_signed;
  logic              lat_rf_en;
  logic              lat_fault;
  logic [DATA_W-1:0] load_result;

  logic              is_mem_op;
  logic              misaligned;
  logic              start_access;
  logic [1:0]        align_addr;
  logic [1:0]        align_size;
  logic              align_signed;
  logic [3:0]        align_be;
  logic [DATA_W-1:0] align_wdata;
  logic [DATA_W-1:0] align_load;

  // op_done marks the first IDLE cycle after a completed transaction. The
  // upstream register still shows the finished instruction then (stall was
  // high on the previous edge), so it must not be started a second time;
  // stall is low in that cycle and upstream advances on its edge.
  always_comb begin
    is_mem_op    = load_in | store_in;
    misaligned   = is_misaligned(size_in, addr_in[1:0]);
    start_access = (state == IDLE) && !op_done && is_mem_op && !misaligned;
    stall        = reset_n && ((state != IDLE) || start_access);
  end

  // In IDLE the lane logic sees the live inputs so the request can be
  // registered on entry; afterwards it sees the latched fields so load data
  // can be extracted when mem_ack arrives.
  always_comb begin
    if (state == IDLE) begin
      align_addr   = addr_in[1:0];
      align_size   = size_in;
      align_signed = signed_in;
    end else begin
      align_addr   = lat_addr[1:0];
      align_size   = lat_size;
      align_signed = lat_signed;
    end
  end

  mem_lane_align u_lane_align (
    .addr_lo       (align_addr),
    .size          (align_size),
    .signed_ext    (align_signed),
    .little_endian (LITTLE_ENDIAN),
    .store_data    (store_data_in),
    .load_raw      (mem_rdata),
    .be            (align_be),
    .wdata         (align_wdata),
    .load_data     (align_load)
  );

  // Main FSM. IDLE handles pass-through and misaligned ops in a single
  // cycle; aligned loads/stores go through ACCESS (request held until ack or
  // timeout) and WAIT_WB (MEM/WB update). mem_fault defaults low so it can
  // only ever be a single-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      op_done     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      lat_addr    <= '0;
      lat_rd      <= '0;
      lat_size    <= SZ_BYTE;
      lat_load    <= 1'b0;
      lat_signed  <= 1'b0;
      lat_rf_en   <= 1'b0;
      lat_fault   <= 1'b0;
      load_result <= '0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_rf_en    <= 1'b0;
      mem_fault   <= 1'b0;
    end else begin
      mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          op_done <= 1'b0;
          if (!op_done) begin
            if (start_access) begin
              lat_addr   <= addr_in;
              lat_rd     <= rd_in;
              lat_size   <= size_in;
              lat_load   <= load_in & ~store_in;
              lat_signed <= signed_in;
              lat_rf_en  <= rf_en_in;
              lat_fault  <= 1'b0;
              count      <= '0;
              mem_req    <= 1'b1;
              mem_we     <= store_in;
              mem_addr   <= {addr_in[DATA_W-1:2], 2'b00};
              mem_be     <= align_be;
              mem_wdata  <= align_wdata;
              state      <= ACCESS;
            end else if (is_mem_op) begin
              mem_fault <= 1'b1;
              wb_data   <= addr_in;
              wb_rd     <= rd_in;
              wb_rf_en  <= 1'b0;
            end else begin
              wb_data  <= addr_in;
              wb_rd    <= rd_in;
              wb_rf_en <= rf_en_in;
            end
          end
        end

        ACCESS: begin
          count <= count + 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= '0;
            if (lat_load) begin
              load_result <= align_load;
            end
            state <= WAIT_WB;
          end else if (count == LAST_CNT) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_fault <= 1'b1;
            lat_fault <= 1'b1;
            state     <= WAIT_WB;
          end
        end

        WAIT_WB: begin
          wb_data  <= (lat_load && !lat_fault) ? load_result : lat_addr;
          wb_rd    <= lat_rd;
          wb_rf_en <= lat_load && !lat_fault && lat_rf_en;
          count    <= '0;
          op_done  <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases, randomized operations
// against a byte-level reference model, and reset during a transaction.
module tb_mem_stage;

  localparam int TIMEOUT = 16;
  localparam bit LE      = 1'b1;

  logic        clk;
  logic        reset_n;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic [3:0]  rd_in;
  logic [1:0]  size_in;
  logic        load_in;
  logic        store_in;
  logic        signed_in;
  logic        rf_en_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic [31:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_rf_en;
  logic        mem_fault;

  int checks;
  int failures;

  typedef struct packed {
    int          stall_cycles;
    int          req_cycles;
    int          fault_cycles;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        we;
    logic        unstable;
    logic        hung;
    logic [31:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_rf_en;
  } obs_t;

  mem_stage #(.TIMEOUT(TIMEOUT), .LITTLE_ENDIAN(LE)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .addr_in       (addr_in),
    .store_data_in (store_data_in),
    .rd_in         (rd_in),
    .size_in       (size_in),
    .load_in       (load_in),
    .store_in      (store_in),
    .signed_in     (signed_in),
    .rf_en_in      (rf_en_in),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .stall         (stall),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_rf_en      (wb_rf_en),
    .mem_fault     (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory byte k of a bus word, honouring the bus byte order.
  function automatic logic [7:0] mbyte(input logic [31:0] w, input int k);
    return LE ? w[8*k +: 8] : w[8*(3-k) +: 8];
  endfunction

  // Reference model: what one operation should look like from outside,
  // derived from byte counts and addresses rather than lane encodings.
  function automatic obs_t model(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] sz, input logic ld,
                                 input logic st, input logic sg,
                                 input logic rfe, input logic [3:0] rd,
                                 input int ack_at, input logic [31:0] rdata);
    obs_t e;
    int n;
    int off;
    logic [31:0] v;
    e = '0;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    e.wb_rd = rd;
    e.addr  = a & 32'hFFFF_FFFC;
    e.we    = st;
    if (!(ld || st)) begin
      e.wb_data  = a;
      e.wb_rf_en = rfe;
    end else if ((off % n) != 0) begin
      e.fault_cycles = 1;
    end else begin
      for (int i = 0; i < n; i++) e.be[LE ? off + i : 3 - (off + i)] = 1'b1;
      if (n == 1)      e.wdata = (d & 32'hFF) * 32'h0101_0101;
      else if (n == 2) e.wdata = (d & 32'hFFFF) * 32'h0001_0001;
      else             e.wdata = d;
      if (ack_at == 0) begin
        e.req_cycles   = TIMEOUT;
        e.stall_cycles = TIMEOUT + 2;
        e.fault_cycles = 1;
      end else begin
        e.req_cycles   = ack_at;
        e.stall_cycles = ack_at + 2;
        v = 32'h0;
        for (int i = 0; i < n; i++)
          v = v | ({24'h0, mbyte(rdata, off + i)} << (8 * (LE ? i : n - 1 - i)));
        if (sg && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        e.wb_data  = (ld && !st) ? v : a;
        e.wb_rf_en = ld && !st && rfe;
      end
    end
    return e;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic ld, input logic st,
                       input logic sg, input logic rfe, input logic [3:0] rd);
    addr_in = a; store_data_in = d; size_in = sz; load_in = ld;
    store_in = st; signed_in = sg; rf_en_in = rfe; rd_in = rd;
  endtask

  task automatic bubble();
    drive(32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  // Presents one instruction, holds it while stall is high, answers the
  // request with mem_ack in request cycle ack_at (0 = never), and records
  // what the DUT did. Called at posedge+1; returns at posedge+1.
  task automatic run_op(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic ld, input logic st,
                        input logic sg, input logic rfe, input logic [3:0] rd,
                        input int ack_at, input logic [31:0] rdata,
                        output obs_t o);
    logic seen_req;
    logic finished;
    logic done;
    o = '0;
    seen_req = 1'b0;
    finished = 1'b0;
    drive(a, d, sz, ld, st, sg, rfe, rd);
    mem_rdata = rdata;
    #1;
    for (int i = 0; i < TIMEOUT + 10; i++) begin
      if (stall) o.stall_cycles++;
      if (mem_fault) o.fault_cycles++;
      if (mem_req) begin
        o.req_cycles++;
        if (!seen_req) begin
          o.be = mem_be; o.wdata = mem_wdata; o.addr = mem_addr; o.we = mem_we;
          seen_req = 1'b1;
        end else if (mem_be !== o.be || mem_wdata !== o.wdata ||
                     mem_addr !== o.addr || mem_we !== o.we) begin
          o.unstable = 1'b1;
        end
      end
      mem_ack = mem_req && (o.req_cycles == ack_at);
      done = !stall;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (done) begin
        finished = 1'b1;
        break;
      end
    end
    o.hung = !finished;
    bubble();
    #1;
    if (mem_fault) o.fault_cycles++;
    o.wb_data = wb_data; o.wb_rd = wb_rd; o.wb_rf_en = wb_rf_en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bubble();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    reset_n = 1'b0;
    #12;
    checks++;
    if ({mem_req, mem_we, stall, wb_rf_en, mem_fault} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, stall, wb_rf_en, mem_fault});
    end
    checks++;
    if (wb_data !== 32'h0 || wb_rd !== 4'h0 || mem_be !== 4'h0) begin
      failures++;
      $display("[TB] FAIL reset_data got wb_data=%h wb_rd=%h be=%b exp 0", wb_data, wb_rd, mem_be);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    obs_t o;
    run_op(32'h100, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1, 32'hDEAD_BEEF, o);
    checks++;
    if (o.stall_cycles !== 3 || o.hung) begin
      failures++; $display("[TB] FAIL word_load_stall got=%0d hung=%b exp=3", o.stall_cycles, o.hung);
    end
    checks++;
    if (o.wb_data !== 32'hDEAD_BEEF || o.wb_rf_en !== 1'b1 || o.wb_rd !== 4'd3) begin
      failures++; $display("[TB] FAIL word_load_wb got=%h/%b/%h exp=deadbeef/1/3", o.wb_data, o.wb_rf_en, o.wb_rd);
    end

    run_op(32'h103, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 1, 32'h80FF_FF00, o);
    checks++;
    if (o.be !== 4'b1000 || o.wb_data !== 32'hFFFF_FF80) begin
      failures++; $display("[TB] FAIL sbyte_load got be=%b data=%h exp 1000/ffffff80", o.be, o.wb_data);
    end
    run_op(32'h103, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1, 32'h80FF_FF00, o);
    checks++;
    if (o.wb_data !== 32'h0000_0080) begin
      failures++; $display("[TB] FAIL ubyte_load got=%h exp=00000080", o.wb_data);
    end

    run_op(32'h202, 32'h1234_ABCD, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 2, 32'h0, o);
    checks++;
    if (o.we !== 1'b1 || o.be !== 4'b1100 || o.wdata !== 32'hABCD_ABCD || o.addr !== 32'h200) begin
      failures++; $display("[TB] FAIL half_store_req got we=%b be=%b wdata=%h addr=%h", o.we, o.be, o.wdata, o.addr);
    end
    checks++;
    if (o.wb_rf_en !== 1'b0 || o.stall_cycles !== 4 || o.unstable) begin
      failures++; $display("[TB] FAIL half_store_wb got rf_en=%b stall=%0d unstable=%b exp 0/4/0", o.wb_rf_en, o.stall_cycles, o.unstable);
    end

    run_op(32'h301, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 1, 32'h0, o);
    checks++;
    if (o.req_cycles !== 0 || o.fault_cycles !== 1 || o.stall_cycles !== 0 || o.wb_rf_en !== 1'b0) begin
      failures++; $display("[TB] FAIL misaligned got req=%0d fault=%0d stall=%0d rf_en=%b exp 0/1/0/0", o.req_cycles, o.fault_cycles, o.stall_cycles, o.wb_rf_en);
    end

    run_op(32'h400, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 0, 32'h0, o);
    checks++;
    if (o.req_cycles !== TIMEOUT || o.fault_cycles !== 1 || o.hung) begin
      failures++; $display("[TB] FAIL timeout_req got req=%0d fault=%0d hung=%b exp %0d/1/0", o.req_cycles, o.fault_cycles, o.hung, TIMEOUT);
    end
    checks++;
    if (o.wb_rf_en !== 1'b0 || o.stall_cycles !== TIMEOUT + 2) begin
      failures++; $display("[TB] FAIL timeout_wb got rf_en=%b stall=%0d exp 0/%0d", o.wb_rf_en, o.stall_cycles, TIMEOUT + 2);
    end

    run_op(32'h1234_5678, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 1, 32'h0, o);
    checks++;
    if (o.wb_data !== 32'h1234_5678 || o.wb_rd !== 4'd15 || o.wb_rf_en !== 1'b1 || o.stall_cycles !== 0) begin
      failures++; $display("[TB] FAIL passthru_pc got %h/%h/%b stall=%0d", o.wb_data, o.wb_rd, o.wb_rf_en, o.stall_cycles);
    end
  endtask

  task automatic test_random();
    obs_t o;
    obs_t e;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a, d, rdata;
      logic [1:0] sz;
      logic ld, st, sg, rfe;
      logic [3:0] rd;
      int kind, ack_at;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      d = $urandom; rdata = $urandom;
      sz = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 4);
      ld = (kind == 1 || kind == 2 || kind == 4);
      st = (kind == 3 || kind == 4);
      sg = 1'($urandom_range(0, 1));
      rfe = 1'($urandom_range(0, 1));
      rd = 4'($urandom_range(0, 15));
      ack_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      e = model(a, d, sz, ld, st, sg, rfe, rd, ack_at, rdata);
      run_op(a, d, sz, ld, st, sg, rfe, rd, ack_at, rdata, o);
      checks++;
      if (o.hung || o.stall_cycles !== e.stall_cycles || o.req_cycles !== e.req_cycles ||
          o.fault_cycles !== e.fault_cycles) begin
        failures++;
        $display("[TB] FAIL rand%0d_timing got stall=%0d req=%0d fault=%0d hung=%b exp %0d/%0d/%0d",
                 t, o.stall_cycles, o.req_cycles, o.fault_cycles, o.hung,
                 e.stall_cycles, e.req_cycles, e.fault_cycles);
      end
      checks++;
      if (o.wb_rf_en !== e.wb_rf_en) begin
        failures++; $display("[TB] FAIL rand%0d_rf_en got=%b exp=%b", t, o.wb_rf_en, e.wb_rf_en);
      end
      if (e.fault_cycles == 0) begin
        checks++;
        if (o.wb_data !== e.wb_data || o.wb_rd !== e.wb_rd) begin
          failures++; $display("[TB] FAIL rand%0d_wb got=%h/%h exp=%h/%h", t, o.wb_data, o.wb_rd, e.wb_data, e.wb_rd);
        end
      end
      if (e.req_cycles > 0) begin
        checks++;
        if (o.be !== e.be || o.addr !== e.addr || o.we !== e.we || o.unstable ||
            (e.we && o.wdata !== e.wdata)) begin
          failures++;
          $display("[TB] FAIL rand%0d_req got be=%b addr=%h we=%b wdata=%h unstable=%b exp be=%b addr=%h we=%b wdata=%h",
                   t, o.be, o.addr, o.we, o.wdata, o.unstable, e.be, e.addr, e.we, e.wdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(32'h500, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9);
    mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (mem_req !== 1'b1 || stall !== 1'b1) begin
      failures++; $display("[TB] FAIL mid_access got req=%b stall=%b exp 1/1", mem_req, stall);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, stall, wb_rf_en, mem_fault} !== 5'b0 || wb_data !== 32'h0 ||
        wb_rd !== 4'h0 || mem_be !== 4'h0) begin
      failures++;
      $display("[TB] FAIL mid_reset got ctrl=%b wb_data=%h wb_rd=%h be=%b exp all 0",
               {mem_req, mem_we, stall, wb_rf_en, mem_fault}, wb_data, wb_rd, mem_be);
    end
    bubble();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (wb_rf_en !== 1'b0 || wb_data !== 32'h0 || mem_req !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL late_ack got rf_en=%b wb_data=%h req=%b stall=%b exp 0", wb_rf_en, wb_data, mem_req, stall);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
